mem_initiator: RTL and testbench
================================

// Module: mem_initiator
// PURPOSE
//  CPU-side bus master for the KV10 memory port. Accepts one read or write request from
//  the CPU, drives mem_addr/mem_read/mem_write toward the memory responder, waits for
//  read_ack/write_ack, returns read data and a completion pulse. Optional timeout flags
//  non-existent memory (NXM). Sits between the CPU datapath and the mem block.
// PARAMETERS
//  TIMEOUT  15  cycles in READ/WRITE without ack before NXM abort (timeout build only)
//  TMR_W    $clog2(TIMEOUT+1)  timeout counter width (derived; do not override)
// PORTS
//  clk             in   1        system clock; all state on posedge
//  reset           in   1        synchronous, active-low reset (0 = reset)
//  cpu_req         in   1        request valid; accepted when cpu_req && cpu_ready
//  cpu_we          in   1        1 = write, 0 = read; sampled at acceptance
//  cpu_addr        in   `PADDR   physical address; sampled at acceptance
//  cpu_wdata       in   `WORD    write data; sampled at acceptance
//  cpu_ready       out  1        initiator idle, can accept a request this cycle
//  cpu_done        out  1        one-cycle completion pulse (read or write, incl. NXM)
//  cpu_rdata       out  `WORD    read data; valid while cpu_done=1, held until next done
//  cpu_nxm         out  1        with cpu_done: transaction aborted by timeout
//  mem_addr        out  `PADDR   to memory
//  mem_write_data  out  `WORD    to memory
//  mem_read        out  1        read strobe, held until read_ack
//  mem_write       out  1        write strobe, held until write_ack
//  mem_read_data   in   `WORD    from memory; valid the cycle after read_ack
//  read_ack        in   1        may be combinational from mem_read
//  write_ack       in   1        may be combinational from mem_write
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; cpu_ready=1; cpu_done=0; cpu_nxm=0;
//    cpu_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_write_data=0; timer=0.
//    Reset mid-transaction abandons it: strobes low next cycle, no cpu_done issued.
//  - All outputs registered; cpu_ready=1 exactly in IDLE.
//  - States: IDLE, READ, RDATA, WRITE.
//  - IDLE: on cpu_req: latch cpu_addr->mem_addr, cpu_wdata->mem_write_data, clear
//    timer; cpu_we=1 -> WRITE (mem_write=1), else -> READ (mem_read=1).
//  - READ: read_ack=1 -> RDATA, mem_read=0. Else timer++.
//  - RDATA: cpu_rdata<=mem_read_data; cpu_done<=1, cpu_nxm<=0; -> IDLE.
//  - WRITE: write_ack=1 -> IDLE, mem_write=0, cpu_done<=1, cpu_nxm<=0. Else timer++.
//  - cpu_done is a single-cycle pulse coinciding with first IDLE cycle; a new cpu_req in
//    that cycle is accepted (back-to-back).
//  - Latency (zero-wait memory): read req at cycle 0 -> mem_read cycle 1 -> done cycle 3;
//    write req cycle 0 -> mem_write cycle 1 -> done cycle 2. Each wait cycle adds one.
//  - Ack in wrong state (read_ack in WRITE/IDLE, write_ack in READ/IDLE) ignored.
//  - cpu_req while cpu_ready=0 ignored; CPU holds request until accepted.
//  - mem_addr/mem_write_data stable for the whole strobe duration.
// CONFIGURATION
//  MEM_INITIATOR_TIMEOUT_EN defined: in READ/WRITE, when timer==TIMEOUT and no ack that
//    cycle: drop strobe, -> IDLE, cpu_done=1, cpu_nxm=1, cpu_rdata=0. Ack in the same
//    cycle timer==TIMEOUT wins (normal completion). Abort after TIMEOUT+1 strobe cycles.
//  Not defined: no timer logic; waits indefinitely for ack; cpu_nxm tied 0.
// TESTING
//  1 Reset: hold reset=0 3 cycles mid-read -> mem_read=0, cpu_ready=1, no cpu_done.
//  2 Read, zero-wait: req addr=0o1000, mem returns 36'o123456701234 -> mem_read high
//    1 cycle (cycle 1), cpu_done cycle 3, cpu_rdata=36'o123456701234, cpu_nxm=0.
//  3 Write, 3 wait states: addr=0o2000, data=36'o777777000000, write_ack at 4th strobe
//    cycle -> mem_write high 4 cycles, addr/data stable, cpu_done 1 cycle later.
//  4 Back-to-back: write then read same addr issued in done cycle -> read returns written
//    value; no idle gap beyond the done cycle.
//  5 TIMEOUT_EN, no ack: read, TIMEOUT=15 -> mem_read high 16 cycles, then cpu_done=1,
//    cpu_nxm=1, cpu_rdata=0; ack on 16th cycle instead -> normal read, cpu_nxm=0.
//  6 Spurious read_ack during WRITE and in IDLE -> no state change, no cpu_done.

Source files
------------

// File: rtl/mem_initiator_if.sv
// KV10 memory-port bus between the CPU-side initiator and the memory responder.
// master = mem_initiator, slave = memory responder.
`ifndef PADDR
`define PADDR [17:0]
`endif
`ifndef WORD
`define WORD [35:0]
`endif

interface mem_initiator_if;
    logic `PADDR mem_addr;
    logic `WORD  mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic `WORD  mem_read_data;
    logic        read_ack;
    logic        write_ack;

    modport master (
        output mem_addr, mem_write_data, mem_read, mem_write,
        input  mem_read_data, read_ack, write_ack
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_read, mem_write,
        output mem_read_data, read_ack, write_ack
    );
endinterface

// File: rtl/mem_initiator.sv
// CPU-side bus master for the KV10 memory port: one read/write at a time.
// Define MEM_INITIATOR_TIMEOUT_EN to abort un-acked cycles as NXM.
`ifndef PADDR
`define PADDR [17:0]
`endif
`ifndef WORD
`define WORD [35:0]
`endif

module mem_initiator #(
    parameter  int TIMEOUT = 15,
    localparam int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic `PADDR cpu_addr,
    input  logic `WORD  cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic `WORD  cpu_rdata,
    output logic        cpu_nxm,
    mem_initiator_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0] state;

`ifdef MEM_INITIATOR_TIMEOUT_EN
    logic [TMR_W-1:0] timer;
    logic             tmo;

    assign tmo = (timer == TMR_W'(TIMEOUT));

    // Strobe-cycle counter; cleared at acceptance, advanced while no ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == IDLE) begin
            if (cpu_req)
                timer <= '0;
        end else if ((state == READ && !bus.read_ack) ||
                     (state == WRITE && !bus.write_ack)) begin
            if (!tmo)
                timer <= timer + 1'b1;
        end
    end
`else
    // No abort path: the parameter has no effect in this build.
    assign cpu_nxm = (TIMEOUT < 0);
`endif

    // Transaction FSM with registered CPU and bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            cpu_ready          <= 1'b1;
            cpu_done           <= 1'b0;
            cpu_rdata          <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            cpu_nxm            <= 1'b0;
`endif
        end else begin
            cpu_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        bus.mem_addr       <= cpu_addr;
                        bus.mem_write_data <= cpu_wdata;
                        cpu_ready          <= 1'b0;
                        if (cpu_we) begin
                            state         <= WRITE;
                            bus.mem_write <= 1'b1;
                        end else begin
                            state        <= READ;
                            bus.mem_read <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (bus.read_ack) begin
                        state        <= RDATA;
                        bus.mem_read <= 1'b0;
                    end
`ifdef MEM_INITIATOR_TIMEOUT_EN
                    else if (tmo) begin
                        state        <= IDLE;
                        bus.mem_read <= 1'b0;
                        cpu_ready    <= 1'b1;
                        cpu_done     <= 1'b1;
                        cpu_nxm      <= 1'b1;
                        cpu_rdata    <= '0;
                    end
`endif
                end
                RDATA: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                    cpu_done  <= 1'b1;
                    cpu_rdata <= bus.mem_read_data;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                    cpu_nxm   <= 1'b0;
`endif
                end
                WRITE: begin
                    if (bus.write_ack) begin
                        state         <= IDLE;
                        bus.mem_write <= 1'b0;
                        cpu_ready     <= 1'b1;
                        cpu_done      <= 1'b1;
`ifdef MEM_INITIATOR_TIMEOUT_EN
                        cpu_nxm       <= 1'b0;
`endif
                    end
`ifdef MEM_INITIATOR_TIMEOUT_EN
                    else if (tmo) begin
                        state         <= IDLE;
                        bus.mem_write <= 1'b0;
                        cpu_ready     <= 1'b1;
                        cpu_done      <= 1'b1;
                        cpu_nxm       <= 1'b1;
                        cpu_rdata     <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator with a wait-state memory model.
// Timeout cases run only when MEM_INITIATOR_TIMEOUT_EN is defined.
`ifndef PADDR
`define PADDR [17:0]
`endif
`ifndef WORD
`define WORD [35:0]
`endif

module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic `PADDR cpu_addr = '0;
    logic `WORD  cpu_wdata = '0;
    logic        cpu_ready;
    logic        cpu_done;
    logic `WORD  cpu_rdata;
    logic        cpu_nxm;

    mem_initiator_if bus ();

    mem_initiator dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_nxm   (cpu_nxm),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    // Memory responder model
    int         wait_n = 0;
    int         wcnt = 0;
    bit         mute = 1'b0;
    bit         spur_rack = 1'b0;
    bit         spur_wack = 1'b0;
    logic `WORD mem [64];
    logic `WORD rd_q = '0;

    assign bus.read_ack  = spur_rack ||
        (bus.mem_read && !mute && wcnt == wait_n);
    assign bus.write_ack = spur_wack ||
        (bus.mem_write && !mute && wcnt == wait_n);
    assign bus.mem_read_data = rd_q;

    always @(posedge clk) begin
        if ((bus.mem_read && !bus.read_ack) ||
            (bus.mem_write && !bus.write_ack))
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
        if (bus.mem_write && bus.write_ack)
            mem[bus.mem_addr[11:6]] <= bus.mem_write_data;
        if (bus.mem_read && bus.read_ack)
            rd_q <= mem[bus.mem_addr[11:6]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request at the current negedge and follow it to cpu_done.
    // Returns at the negedge of the done cycle.
    task automatic txn(input string tag,
                       input bit we,
                       input logic `PADDR a,
                       input logic `WORD d,
                       input int exp_strb,
                       input int exp_lat,
                       input bit chk_rd,
                       input logic `WORD exp_rd,
                       input bit exp_nxm);
        int  strb = 0;
        int  cyc = 0;
        bit  got = 1'b0;
        check({tag, " ready"}, 64'(cpu_ready), 64'd1);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_addr  = ~a;
        cpu_wdata = ~d;
        cyc = 1;
        while (!got && cyc < 60) begin
            if (we ? bus.mem_write : bus.mem_read) begin
                strb++;
                if (bus.mem_addr !== a)
                    check({tag, " addr"}, 64'(bus.mem_addr), 64'(a));
                if (we && bus.mem_write_data !== d)
                    check({tag, " wdata"}, 64'(bus.mem_write_data), 64'(d));
            end
            if (cpu_done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done seen"}, 64'(got), 64'd1);
        check({tag, " strobes"}, 64'(strb), 64'(exp_strb));
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " nxm"}, 64'(cpu_nxm), 64'(exp_nxm));
        check({tag, " strobe off"},
              64'(bus.mem_read | bus.mem_write), 64'd0);
        if (chk_rd)
            check({tag, " rdata"}, 64'(cpu_rdata), 64'(exp_rd));
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = '0;
        mem[8] = 36'o123456701234;

        repeat (3) @(negedge clk);
        check("rst ready", 64'(cpu_ready), 64'd1);
        check("rst done", 64'(cpu_done), 64'd0);
        check("rst nxm", 64'(cpu_nxm), 64'd0);
        check("rst rdata", 64'(cpu_rdata), 64'd0);
        check("rst strobes",
              64'({bus.mem_read, bus.mem_write}), 64'd0);
        check("rst addr", 64'(bus.mem_addr), 64'd0);
        check("rst wdata", 64'(bus.mem_write_data), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-read abandons the transaction
        wait_n  = 20;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_addr = 18'o1000;
        @(negedge clk);
        cpu_req = 1'b0;
        check("mid rd strobe", 64'(bus.mem_read), 64'd1);
        check("mid rd busy", 64'(cpu_ready), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid rst strobe", 64'(bus.mem_read), 64'd0);
            check("mid rst ready", 64'(cpu_ready), 64'd1);
            check("mid rst done", 64'(cpu_done), 64'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post rst done", 64'(cpu_done), 64'd0);
        end
        wait_n = 0;

        // Zero-wait read
        txn("rd0", 1'b0, 18'o1000, '0, 1, 3,
            1'b1, 36'o123456701234, 1'b0);
        @(negedge clk);
        check("rd0 pulse", 64'(cpu_done), 64'd0);
        check("rd0 hold", 64'(cpu_rdata), 64'(36'o123456701234));

        // Write with three wait states
        wait_n = 3;
        txn("wr3", 1'b1, 18'o2000, 36'o777777000000, 4, 5,
            1'b0, '0, 1'b0);
        check("wr3 mem", 64'(mem[16]), 64'(36'o777777000000));
        @(negedge clk);
        wait_n = 0;

        // Back-to-back write then read in the done cycle
        txn("b2b wr", 1'b1, 18'o3000, 36'o135702461357, 1, 2,
            1'b0, '0, 1'b0);
        txn("b2b rd", 1'b0, 18'o3000, '0, 1, 3,
            1'b1, 36'o135702461357, 1'b0);
        @(negedge clk);

        // Spurious acks: idle, during write, during read
        spur_rack = 1'b1;
        spur_wack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("spur idle ready", 64'(cpu_ready), 64'd1);
            check("spur idle done", 64'(cpu_done), 64'd0);
        end
        spur_wack = 1'b0;
        wait_n = 2;
        txn("spur wr", 1'b1, 18'o4000, 36'o000123000456, 3, 4,
            1'b0, '0, 1'b0);
        @(negedge clk);
        spur_rack = 1'b0;
        spur_wack = 1'b1;
        txn("spur rd", 1'b0, 18'o4000, '0, 3, 5,
            1'b1, 36'o000123000456, 1'b0);
        spur_wack = 1'b0;
        @(negedge clk);
        wait_n = 0;

`ifdef MEM_INITIATOR_TIMEOUT_EN
        mute = 1'b1;
        txn("tmo rd", 1'b0, 18'o1000, '0, 16, 17,
            1'b1, '0, 1'b1);
        @(negedge clk);
        txn("tmo wr", 1'b1, 18'o5000, 36'o1, 16, 17,
            1'b1, '0, 1'b1);
        check("tmo wr mem", 64'(mem[40]), 64'd0);
        @(negedge clk);
        mute = 1'b0;
        wait_n = 15;
        txn("ack16 rd", 1'b0, 18'o1000, '0, 16, 18,
            1'b1, 36'o123456701234, 1'b0);
        @(negedge clk);
        wait_n = 0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
